lsu_sequencer: RTL and testbench

Multi-cycle load/store sequencer for the memory stage of the RISC-V core. It takes the decoded `mem_rd`, `mem_wr` and `rw_type` (funct3) signals together with the ALU-computed address and store data. It runs one data-bus transaction with a req/gnt/rvalid handshake and stalls the pipeline while the transaction is in flight. It also generates byte enables and store-data lane replication, formats load data (sign/zero extension), and flags misaligned, illegal and timed-out accesses.

---
 rtl/lsu_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_lsu_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lsu_sequencer
// Brief    : Memory-stage load/store sequencer with req/gnt/rvalid bus,
//            lane steering, load formatting and fault reporting.
// Revision : 1.0
// ============================================================================
module lsu_sequencer #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_mem_rd,
    input  logic        i_mem_wr,
    input  logic [2:0]  i_rw_type,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_flush,
    output logic        o_stall,
    output logic [31:0] o_rdata,
    output logic        o_rdata_valid,
    output logic        o_exc,
    output logic [1:0]  o_exc_cause,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_gnt,
    input  logic        i_bus_rvalid,
    input  logic [31:0] i_bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [7:0] c_LAST = 8'(MAX_WAIT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [2:0]  r_type;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [7:0]  r_cnt;
    logic        r_kill;
    logic [31:0] r_rdata;
    logic        r_rdata_valid;
    logic        r_exc;
    logic [1:0]  r_exc_cause;

    logic        w_access;
    logic        w_illegal;
    logic        w_misal;
    logic        w_start;
    logic        w_fault;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_fmt;

    assign w_access  = (i_mem_rd | i_mem_wr) & ~i_flush;
    assign w_illegal = (i_mem_rd & i_mem_wr)
                     | (i_mem_wr & (i_rw_type[2] | (i_rw_type == 3'b011)))
                     | (i_mem_rd & ((i_rw_type == 3'b011) | (i_rw_type[2:1] == 2'b11)));
    assign w_misal   = ((i_rw_type[1:0] == 2'b01) & i_addr[0])
                     | ((i_rw_type[1:0] == 2'b10) & (i_addr[1:0] != 2'b00));
    assign w_start   = w_access & ~w_illegal & ~w_misal;
    assign w_fault   = w_access & (w_illegal | w_misal);
    assign w_timeout = (r_cnt == c_LAST);

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_wdata;
        if (i_mem_wr) begin
            case (i_rw_type[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << i_addr[1:0];
                    w_wdata = {4{i_wdata[7:0]}};
                end
                2'b01: begin
                    w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{i_wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (r_addr[1:0])
            2'b00:   w_byte = i_bus_rdata[7:0];
            2'b01:   w_byte = i_bus_rdata[15:8];
            2'b10:   w_byte = i_bus_rdata[23:16];
            default: w_byte = i_bus_rdata[31:24];
        endcase
        w_half = r_addr[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        case (r_type)
            3'b000:  w_fmt = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_fmt = {{16{w_half[15]}}, w_half};
            3'b100:  w_fmt = {24'd0, w_byte};
            3'b101:  w_fmt = {16'd0, w_half};
            default: w_fmt = i_bus_rdata;
        endcase
    end

    // A grant always wins over flush/timeout because the bus has already taken it.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start)      w_next = S_REQ;
                else if (w_fault) w_next = S_DONE;
            end
            S_REQ: begin
                if (i_bus_gnt)      w_next = r_we ? S_DONE : S_WAIT;
                else if (i_flush)   w_next = S_IDLE;
                else if (w_timeout) w_next = S_DONE;
            end
            S_WAIT: begin
                if (i_bus_rvalid | w_timeout) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_type        <= '0;
            r_we          <= 1'b0;
            r_be          <= '0;
            r_wdata       <= '0;
            r_cnt         <= '0;
            r_kill        <= 1'b0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_exc         <= 1'b0;
            r_exc_cause   <= '0;
        end else begin
            r_state       <= w_next;
            r_rdata_valid <= 1'b0;
            r_exc         <= 1'b0;
            r_exc_cause   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_addr  <= i_addr;
                        r_type  <= i_rw_type;
                        r_we    <= i_mem_wr;
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        r_cnt   <= '0;
                        r_kill  <= 1'b0;
                    end else if (w_fault) begin
                        r_exc       <= 1'b1;
                        r_exc_cause <= w_illegal ? 2'b10 : 2'b01;
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (i_bus_gnt) begin
                        if (i_flush & ~r_we) r_kill <= 1'b1;
                    end else if (~i_flush & w_timeout) begin
                        r_exc       <= 1'b1;
                        r_exc_cause <= 2'b11;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (i_flush) r_kill <= 1'b1;
                    if (i_bus_rvalid) begin
                        if (~(r_kill | i_flush)) begin
                            r_rdata_valid <= 1'b1;
                            r_rdata       <= w_fmt;
                        end
                    end else if (w_timeout) begin
                        r_exc       <= 1'b1;
                        r_exc_cause <= 2'b11;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_stall       = rst_n & (((r_state == S_IDLE) & w_start)
                                    | (r_state == S_REQ) | (r_state == S_WAIT));
    assign o_bus_req     = (r_state == S_REQ);
    assign o_bus_we      = (r_state == S_REQ) & r_we;
    assign o_bus_addr    = {r_addr[31:2], 2'b00};
    assign o_bus_be      = r_be;
    assign o_bus_wdata   = r_wdata;
    assign o_rdata       = r_rdata;
    assign o_rdata_valid = r_rdata_valid;
    assign o_exc         = r_exc;
    assign o_exc_cause   = r_exc_cause;

endmodule
`default_nettype wire

// File: tb/tb_lsu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_sequencer
// Brief    : Directed, table-driven bench for lsu_sequencer (MAX_WAIT = 4).
// Revision : 1.0
// ============================================================================
module tb_lsu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_mem_rd = 1'b0, i_mem_wr = 1'b0, i_flush = 1'b0;
    logic [2:0]  i_rw_type = '0;
    logic [31:0] i_addr = '0, i_wdata = '0, i_bus_rdata = '0;
    logic        i_bus_gnt = 1'b0, i_bus_rvalid = 1'b0;
    logic        o_stall, o_rdata_valid, o_exc, o_bus_req, o_bus_we;
    logic [31:0] o_rdata, o_bus_addr, o_bus_wdata;
    logic [1:0]  o_exc_cause;
    logic [3:0]  o_bus_be;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_sequencer #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_mem_rd(i_mem_rd), .i_mem_wr(i_mem_wr), .i_rw_type(i_rw_type),
        .i_addr(i_addr), .i_wdata(i_wdata), .i_flush(i_flush),
        .o_stall(o_stall), .o_rdata(o_rdata), .o_rdata_valid(o_rdata_valid),
        .o_exc(o_exc), .o_exc_cause(o_exc_cause),
        .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
        .o_bus_be(o_bus_be), .o_bus_wdata(o_bus_wdata),
        .i_bus_gnt(i_bus_gnt), .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brdata;
        logic        exc;
        logic [1:0]  cause;
        logic [3:0]  be;
        logic [31:0] bwdata;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_access();
        i_mem_rd = 1'b0;
        i_mem_wr = 1'b0;
        i_flush  = 1'b0;
    endtask

    // One full transaction: grant in the first REQ cycle, rvalid in the first WAIT cycle.
    task automatic run_vec(input vec_t v, input string tag);
        i_mem_rd  = v.rd;
        i_mem_wr  = v.wr;
        i_rw_type = v.typ;
        i_addr    = v.addr;
        i_wdata   = v.wdata;
        i_flush   = 1'b0;
        #1;
        chk({tag, ".accept_stall"}, o_stall, !v.exc);
        tick();
        if (v.exc) begin
            chk({tag, ".exc"}, o_exc, 1'b1);
            chk({tag, ".cause"}, o_exc_cause, v.cause);
            chk({tag, ".no_req"}, o_bus_req, 1'b0);
            chk({tag, ".done_stall"}, o_stall, 1'b0);
            drop_access();
            tick();
            chk({tag, ".exc_pulse"}, o_exc, 1'b0);
        end else begin
            chk({tag, ".req"}, o_bus_req, 1'b1);
            chk({tag, ".addr"}, o_bus_addr, {v.addr[31:2], 2'b00});
            chk({tag, ".be"}, o_bus_be, v.be);
            chk({tag, ".we"}, o_bus_we, v.wr);
            if (v.wr) chk({tag, ".wdata"}, o_bus_wdata, v.bwdata);
            i_bus_gnt = 1'b1;
            tick();
            i_bus_gnt = 1'b0;
            if (!v.rd) begin
                chk({tag, ".done_stall"}, o_stall, 1'b0);
                chk({tag, ".done_req"}, o_bus_req, 1'b0);
                drop_access();
                tick();
            end else begin
                chk({tag, ".wait_stall"}, o_stall, 1'b1);
                i_bus_rdata  = v.brdata;
                i_bus_rvalid = 1'b1;
                tick();
                i_bus_rvalid = 1'b0;
                chk({tag, ".rvalid"}, o_rdata_valid, 1'b1);
                chk({tag, ".rdata"}, o_rdata, v.rdata);
                chk({tag, ".done_stall"}, o_stall, 1'b0);
                drop_access();
                tick();
                chk({tag, ".rvalid_pulse"}, o_rdata_valid, 1'b0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] prev;
        int n;
        int stall_cnt;

        //             rd wr typ     addr        wdata         brdata        exc cause be      bwdata        rdata
        vecs[0]  = '{1, 0, 3'b000, 32'h103, 32'h0,        32'h80FFFF12, 0, 2'b00, 4'hF, 32'h0,        32'hFFFFFF80};
        vecs[1]  = '{1, 0, 3'b100, 32'h103, 32'h0,        32'h80FFFF12, 0, 2'b00, 4'hF, 32'h0,        32'h00000080};
        vecs[2]  = '{1, 0, 3'b001, 32'h102, 32'h0,        32'h80011234, 0, 2'b00, 4'hF, 32'h0,        32'hFFFF8001};
        vecs[3]  = '{1, 0, 3'b101, 32'h100, 32'h0,        32'h8001F234, 0, 2'b00, 4'hF, 32'h0,        32'h0000F234};
        vecs[4]  = '{1, 0, 3'b010, 32'h104, 32'h0,        32'hDEADBEEF, 0, 2'b00, 4'hF, 32'h0,        32'hDEADBEEF};
        vecs[5]  = '{1, 0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 0, 2'b00, 4'hF, 32'h0,        32'h0000007F};
        vecs[6]  = '{0, 1, 3'b000, 32'h201, 32'h123456AB, 32'h0,        0, 2'b00, 4'h2, 32'hABABABAB, 32'h0};
        vecs[7]  = '{0, 1, 3'b001, 32'h200, 32'h1234ABCD, 32'h0,        0, 2'b00, 4'h3, 32'hABCDABCD, 32'h0};
        vecs[8]  = '{0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0,        0, 2'b00, 4'hF, 32'hCAFEF00D, 32'h0};
        vecs[9]  = '{1, 0, 3'b010, 32'h006, 32'h0,        32'h0,        1, 2'b01, 4'h0, 32'h0,        32'h0};
        vecs[10] = '{1, 1, 3'b010, 32'h000, 32'h0,        32'h0,        1, 2'b10, 4'h0, 32'h0,        32'h0};
        vecs[11] = '{0, 1, 3'b100, 32'h000, 32'h0,        32'h0,        1, 2'b10, 4'h0, 32'h0,        32'h0};
        vecs[12] = '{1, 0, 3'b011, 32'h000, 32'h0,        32'h0,        1, 2'b10, 4'h0, 32'h0,        32'h0};
        vecs[13] = '{1, 0, 3'b001, 32'h101, 32'h0,        32'h0,        1, 2'b01, 4'h0, 32'h0,        32'h0};
        vecs[14] = '{0, 1, 3'b010, 32'h202, 32'h0,        32'h0,        1, 2'b01, 4'h0, 32'h0,        32'h0};
        vecs[15] = '{0, 1, 3'b001, 32'h203, 32'h0,        32'h0,        1, 2'b01, 4'h0, 32'h0,        32'h0};
        vecs[16] = '{0, 1, 3'b101, 32'h001, 32'h0,        32'h0,        1, 2'b10, 4'h0, 32'h0,        32'h0};

        #1;
        chk("rst.stall", o_stall, 1'b0);
        chk("rst.bus_req", o_bus_req, 1'b0);
        chk("rst.rdata", o_rdata, 32'h0);
        chk("rst.rdata_valid", o_rdata_valid, 1'b0);
        chk("rst.exc", o_exc, 1'b0);
        chk("rst.bus_addr", o_bus_addr, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 17; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
        prev = 32'hDEADBEEF;

        // sh with grant in the third REQ cycle: bus outputs must hold steady
        i_mem_wr = 1'b1; i_rw_type = 3'b001; i_addr = 32'h202; i_wdata = 32'h1234ABCD;
        #1;
        stall_cnt = o_stall ? 1 : 0;
        tick();
        for (int k = 1; k <= 3; k++) begin
            if (o_stall) stall_cnt++;
            chk($sformatf("sh_slow.req%0d", k), o_bus_req, 1'b1);
            chk($sformatf("sh_slow.be%0d", k), o_bus_be, 4'b1100);
            chk($sformatf("sh_slow.wdata%0d", k), o_bus_wdata, 32'hABCDABCD);
            chk($sformatf("sh_slow.addr%0d", k), o_bus_addr, 32'h200);
            if (k == 3) i_bus_gnt = 1'b1;
            tick();
        end
        i_bus_gnt = 1'b0;
        if (o_stall) stall_cnt++;
        chk("sh_slow.stall_cycles", stall_cnt, 4);
        chk("sh_slow.done_req", o_bus_req, 1'b0);
        drop_access();
        tick();

        // load whose grant never comes
        i_mem_rd = 1'b1; i_rw_type = 3'b010; i_addr = 32'h10;
        tick();
        n = 0;
        while (o_bus_req && n < 20) begin
            n++;
            tick();
        end
        chk("timeout.req_cycles", n, 4);
        chk("timeout.exc", o_exc, 1'b1);
        chk("timeout.cause", o_exc_cause, 2'b11);
        chk("timeout.stall", o_stall, 1'b0);
        drop_access();
        tick();
        chk("timeout.exc_pulse", o_exc, 1'b0);

        // timeout and rvalid land on the same WAIT cycle
        i_mem_rd = 1'b1; i_rw_type = 3'b010; i_addr = 32'h14;
        tick(); tick(); tick();
        i_bus_gnt = 1'b1;
        tick();
        i_bus_gnt = 1'b0;
        i_bus_rdata = 32'h5555AAAA; i_bus_rvalid = 1'b1;
        tick();
        i_bus_rvalid = 1'b0;
        chk("to_rvalid.valid", o_rdata_valid, 1'b1);
        chk("to_rvalid.exc", o_exc, 1'b0);
        chk("to_rvalid.rdata", o_rdata, 32'h5555AAAA);
        prev = 32'h5555AAAA;
        drop_access();
        tick();

        // flush before grant
        i_mem_rd = 1'b1; i_rw_type = 3'b010; i_addr = 32'h20;
        tick();
        chk("flush_req.req", o_bus_req, 1'b1);
        i_flush = 1'b1;
        tick();
        chk("flush_req.req_drop", o_bus_req, 1'b0);
        chk("flush_req.stall", o_stall, 1'b0);
        chk("flush_req.exc", o_exc, 1'b0);
        drop_access();
        tick();
        chk("flush_req.idle", o_bus_req, 1'b0);
        chk("flush_req.no_valid", o_rdata_valid, 1'b0);

        // flush during WAIT, response arrives later
        i_mem_rd = 1'b1; i_rw_type = 3'b010; i_addr = 32'h30;
        tick();
        i_bus_gnt = 1'b1;
        tick();
        i_bus_gnt = 1'b0;
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        chk("flush_wait.stall", o_stall, 1'b1);
        i_bus_rdata = 32'h11112222; i_bus_rvalid = 1'b1;
        tick();
        i_bus_rvalid = 1'b0;
        chk("flush_wait.no_valid", o_rdata_valid, 1'b0);
        chk("flush_wait.rdata_kept", o_rdata, prev);
        chk("flush_wait.stall_done", o_stall, 1'b0);
        drop_access();
        tick();

        // flush and grant together: issued, then killed
        i_mem_rd = 1'b1; i_rw_type = 3'b010; i_addr = 32'h34;
        tick();
        i_bus_gnt = 1'b1; i_flush = 1'b1;
        tick();
        i_bus_gnt = 1'b0;
        drop_access();
        chk("flush_gnt.wait_stall", o_stall, 1'b1);
        i_bus_rdata = 32'h33334444; i_bus_rvalid = 1'b1;
        tick();
        i_bus_rvalid = 1'b0;
        chk("flush_gnt.no_valid", o_rdata_valid, 1'b0);
        chk("flush_gnt.rdata_kept", o_rdata, prev);
        tick();

        // stray bus handshakes in IDLE
        i_bus_rvalid = 1'b1; i_bus_gnt = 1'b1; i_bus_rdata = 32'h99999999;
        tick();
        i_bus_rvalid = 1'b0; i_bus_gnt = 1'b0;
        chk("stray.no_valid", o_rdata_valid, 1'b0);
        chk("stray.no_req", o_bus_req, 1'b0);
        chk("stray.rdata_kept", o_rdata, prev);

        // asynchronous reset during WAIT
        i_mem_rd = 1'b1; i_rw_type = 3'b010; i_addr = 32'h40;
        tick();
        i_bus_gnt = 1'b1;
        tick();
        i_bus_gnt = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.bus_req", o_bus_req, 1'b0);
        chk("arst.stall", o_stall, 1'b0);
        chk("arst.rdata", o_rdata, 32'h0);
        chk("arst.valid", o_rdata_valid, 1'b0);
        chk("arst.exc", o_exc, 1'b0);
        chk("arst.be", o_bus_be, 4'h0);
        drop_access();
        tick();
        rst_n = 1'b1;
        tick();
        run_vec(vecs[4], "post_rst_lw");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
